// File: rtl/nibble_stream_sequencer_pkg.sv
// nibble_stream_sequencer_pkg
//    Shared constants and FSM state encoding for the nibble stream sequencer.
//    Default build streams ascending nibble indices; define NSEQ_DESCEND_EN
//    to stream from the top nibble down to nibble 0.
package nibble_stream_sequencer_pkg;

   localparam int NSEQ_NIBBLES = 32;
   localparam int NSEQ_IDXW    = 5;
   localparam int NSEQ_BLK_W   = 128;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } nseq_state_e;

endpackage

// File: rtl/nibble_stream_sequencer_index_counter.sv
// nseq_index_counter
//    Loadable nibble-index counter with enable and terminal-count detect.
//    Counts up by default or down when DOWN is set; the terminal compare is
//    made on the current value, so the counter never steps past LAST on an
//    enable that the caller gates with term_o.
// Ports
//    clock_i  : clock
//    reset_i  : asynchronous active-high reset (index -> 0)
//    load_i   : load START (priority over en_i)
//    en_i     : step the index by one
//    idx_o    : current index
//    term_o   : index equals LAST
module nseq_index_counter #(
   parameter int              IDXW  = 5,
   parameter logic [IDXW-1:0] START = '0,
   parameter logic [IDXW-1:0] LAST  = '1,
   parameter bit              DOWN  = 1'b0
) (
   input  logic            clock_i,
   input  logic            reset_i,
   input  logic            load_i,
   input  logic            en_i,
   output logic [IDXW-1:0] idx_o,
   output logic            term_o
);

   logic [IDXW-1:0] idx_q;
   logic [IDXW-1:0] idx_d;

   always_comb begin
      idx_d = idx_q;
      if (load_i) begin
         idx_d = START;
      end else if (en_i) begin
         idx_d = DOWN ? (idx_q - IDXW'(1)) : (idx_q + IDXW'(1));
      end
   end

   always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i) begin
         idx_q <= '0;
      end else begin
         idx_q <= idx_d;
      end
   end

   assign idx_o  = idx_q;
   assign term_o = (idx_q == LAST);

endmodule

// File: rtl/nibble_stream_sequencer.sv
// nibble_stream_sequencer
//    Accepts a 128-bit block, holds it, and streams it one nibble per
//    handshake to the A5/1 stage through an external nibble-select mux.
//    Optional macro NSEQ_DESCEND_EN: stream from index NIBBLES-1 down to 0.
//
//    state   | meaning
//    --------+---------------------------------------------------
//    IDLE    | blk_ready high, waiting for a block to capture
//    RUN     | nib_valid high, streaming the held block
//
// Ports
//    clock_i / reset_i        : clock, asynchronous active-high reset
//    blk_data_i/blk_valid_i   : incoming block and its valid
//    blk_ready_o              : block accepted this cycle when valid
//    flush_i                  : synchronous abort of the current block
//    mux_in_o / mux_index_o   : held block and nibble select to the mux
//    mux_nibble_i             : selected nibble back from the mux
//    nib_data_o/nib_valid_o   : nibble stream to the A5/1 stage
//    nib_ready_i / nib_last_o : downstream ready, final-nibble marker
module nibble_stream_sequencer
   import nibble_stream_sequencer_pkg::*;
#(
   parameter int NIBBLES = NSEQ_NIBBLES,
   parameter int IDXW    = NSEQ_IDXW
) (
   input  logic                  clock_i,
   input  logic                  reset_i,
   input  logic [NSEQ_BLK_W-1:0] blk_data_i,
   input  logic                  blk_valid_i,
   output logic                  blk_ready_o,
   input  logic                  flush_i,
   output logic [NSEQ_BLK_W-1:0] mux_in_o,
   output logic [IDXW-1:0]       mux_index_o,
   input  logic [3:0]            mux_nibble_i,
   output logic [3:0]            nib_data_o,
   output logic                  nib_valid_o,
   input  logic                  nib_ready_i,
   output logic                  nib_last_o
);

`ifdef NSEQ_DESCEND_EN
   localparam logic [IDXW-1:0] IDX_START = IDXW'(NIBBLES - 1);
   localparam logic [IDXW-1:0] IDX_LAST  = '0;
   localparam bit              IDX_DOWN  = 1'b1;
`else
   localparam logic [IDXW-1:0] IDX_START = '0;
   localparam logic [IDXW-1:0] IDX_LAST  = IDXW'(NIBBLES - 1);
   localparam bit              IDX_DOWN  = 1'b0;
`endif

   nseq_state_e           state_q;
   logic [NSEQ_BLK_W-1:0] hold_q;
   logic                  blk_ready_q;
   logic                  nib_valid_q;

   logic [IDXW-1:0] idx;
   logic            idx_term;
   logic            handshake;
   logic            capture;
   logic            cnt_en;

   assign handshake = nib_valid_q & nib_ready_i;
   assign capture   = (state_q == ST_IDLE) & blk_valid_i & ~flush_i;
   // The last nibble leaves the index parked at its end value; the next
   // capture reloads it, so there is never a wrap into a second pass.
   assign cnt_en    = (state_q == ST_RUN) & handshake & ~flush_i & ~idx_term;

   nseq_index_counter #(
      .IDXW  (IDXW),
      .START (IDX_START),
      .LAST  (IDX_LAST),
      .DOWN  (IDX_DOWN)
   ) u_index (
      .clock_i (clock_i),
      .reset_i (reset_i),
      .load_i  (capture),
      .en_i    (cnt_en),
      .idx_o   (idx),
      .term_o  (idx_term)
   );

   always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i) begin
         state_q     <= ST_IDLE;
         hold_q      <= '0;
         blk_ready_q <= 1'b1;
         nib_valid_q <= 1'b0;
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               if (capture) begin
                  state_q     <= ST_RUN;
                  hold_q      <= blk_data_i;
                  blk_ready_q <= 1'b0;
                  nib_valid_q <= 1'b1;
               end
            end
            ST_RUN: begin
               // flush wins over a coincident handshake
               if (flush_i || (handshake && idx_term)) begin
                  state_q     <= ST_IDLE;
                  blk_ready_q <= 1'b1;
                  nib_valid_q <= 1'b0;
               end
            end
         endcase
      end
   end

   assign blk_ready_o = blk_ready_q;
   assign nib_valid_o = nib_valid_q;
   assign nib_last_o  = nib_valid_q & idx_term;
   assign mux_in_o    = hold_q;
   assign mux_index_o = idx;
   assign nib_data_o  = mux_nibble_i;

endmodule

// File: tb/tb_nibble_stream_sequencer.sv
module tb_nibble_stream_sequencer;

   localparam int NIB = 32;

   logic         clock = 1'b0;
   logic         reset;
   logic [127:0] blk_data;
   logic         blk_valid;
   logic         blk_ready;
   logic         flush;
   logic [127:0] mux_in;
   logic [4:0]   mux_index;
   logic [3:0]   mux_nibble;
   logic [3:0]   nib_data;
   logic         nib_valid;
   logic         nib_ready;
   logic         nib_last;

   always #5 clock = ~clock;

   nibble_stream_sequencer dut (
      .clock_i      (clock),
      .reset_i      (reset),
      .blk_data_i   (blk_data),
      .blk_valid_i  (blk_valid),
      .blk_ready_o  (blk_ready),
      .flush_i      (flush),
      .mux_in_o     (mux_in),
      .mux_index_o  (mux_index),
      .mux_nibble_i (mux_nibble),
      .nib_data_o   (nib_data),
      .nib_valid_o  (nib_valid),
      .nib_ready_i  (nib_ready),
      .nib_last_o   (nib_last)
   );

   // external nibble-select mux
   assign mux_nibble = mux_in[int'(mux_index)*4 +: 4];

   int tests = 0;
   int fails = 0;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // k-th nibble sent maps to this block index
   function automatic int exp_idx(input int k);
`ifdef NSEQ_DESCEND_EN
      return NIB - 1 - k;
`else
      return k;
`endif
   endfunction

   function automatic logic [3:0] nib_of(input logic [127:0] d, input int idx);
      return d[idx*4 +: 4];
   endfunction

   typedef struct {
      logic [127:0] data;
      int           stall_at;    // k at which nib_ready drops
      int           stall_len;
      int           flush_at;    // k at which flush is raised, -1 none
      bit           rand_ready;
      int           exp_cycles;  // capture to blk_ready, -1 unchecked
   } vec_t;

   localparam logic [127:0] D_REF = 128'h0123456789ABCDEF_FEDCBA9876543210;

   vec_t vecs[5];

   task automatic check_nibble(input string tag, input logic [127:0] d, input int k);
      chk({tag, " nib_valid"}, 128'(nib_valid), 128'(1'b1));
      chk({tag, " mux_index"}, 128'(mux_index), 128'(exp_idx(k)));
      chk({tag, " nib_data"}, 128'(nib_data), 128'(nib_of(d, exp_idx(k))));
      chk({tag, " nib_last"}, 128'(nib_last), 128'(k == NIB - 1));
   endtask

   task automatic wait_ready(input string tag);
      for (int w = 0; w < 10 && blk_ready !== 1'b1; w++) @(negedge clock);
      chk({tag, " blk_ready"}, 128'(blk_ready), 128'(1'b1));
   endtask

   task automatic run_block(input vec_t v, input string tag);
      int k = 0;
      int cyc = 0;
      int stalls = 0;
      bit flushed = 1'b0;
      wait_ready(tag);
      blk_data  = v.data;
      blk_valid = 1'b1;
      @(negedge clock);
      blk_valid = 1'b0;
      blk_data  = {$urandom, $urandom, $urandom, $urandom};
      while (blk_ready !== 1'b1 && cyc < 200) begin
         check_nibble(tag, v.data, k);
         if (k == v.stall_at && stalls < v.stall_len) begin
            nib_ready = 1'b0;
            stalls++;
         end else if (v.rand_ready) begin
            nib_ready = ($urandom_range(0, 3) != 0);
         end else begin
            nib_ready = 1'b1;
         end
         if (k == v.flush_at) begin
            flush     = 1'b1;
            nib_ready = 1'b1;
            flushed   = 1'b1;
         end
         @(negedge clock);
         flush = 1'b0;
         cyc++;
         if (nib_ready && !flushed) k++;
      end
      nib_ready = 1'b0;
      chk({tag, " end blk_ready"}, 128'(blk_ready), 128'(1'b1));
      chk({tag, " end nib_valid"}, 128'(nib_valid), 128'(1'b0));
      chk({tag, " end nib_last"}, 128'(nib_last), 128'(1'b0));
      if (v.exp_cycles >= 0) chk({tag, " cycles"}, 128'(cyc), 128'(v.exp_cycles));
      if (flushed) chk({tag, " flush k"}, 128'(k), 128'(v.flush_at));
   endtask

   initial begin
      vec_t rv;
      logic [127:0] d1, d2;
      blk_data  = '0;
      blk_valid = 1'b0;
      flush     = 1'b0;
      nib_ready = 1'b0;
      reset     = 1'b0;
      #1 reset  = 1'b1;
      #1;
      chk("rst blk_ready", 128'(blk_ready), 128'(1'b1));
      chk("rst nib_valid", 128'(nib_valid), 128'(1'b0));
      chk("rst nib_last", 128'(nib_last), 128'(1'b0));
      chk("rst mux_index", 128'(mux_index), 128'(0));
      chk("rst mux_in", mux_in, 128'(0));
      @(negedge clock);
      reset = 1'b0;

      vecs[0] = '{D_REF, -1, 0, -1, 1'b0, 32};
      vecs[1] = '{D_REF, exp_idx(5), 3, -1, 1'b0, 35};
      vecs[2] = '{D_REF, -1, 0, exp_idx(10), 1'b0, exp_idx(10) + 1};
      vecs[3] = '{128'hDEADBEEF_0BADF00D_CAFEBABE_13579BDF, 3, 2, -1, 1'b1, -1};
      vecs[4] = '{128'hFFFF0000_A5A55A5A_12345678_9ABCDEF0, -1, 0, 0, 1'b0, 1};
      for (int i = 0; i < 5; i++) run_block(vecs[i], $sformatf("vec%0d", i));

      // back-to-back with blk_valid held high
      d1 = {$urandom, $urandom, $urandom, $urandom};
      d2 = {$urandom, $urandom, $urandom, $urandom};
      wait_ready("b2b");
      blk_data  = d1;
      blk_valid = 1'b1;
      nib_ready = 1'b1;
      @(negedge clock);
      for (int k = 0; k < NIB; k++) begin
         check_nibble("b2b blk1", d1, k);
         @(negedge clock);
      end
      chk("b2b bubble nib_valid", 128'(nib_valid), 128'(1'b0));
      chk("b2b bubble blk_ready", 128'(blk_ready), 128'(1'b1));
      blk_data = d2;
      @(negedge clock);
      blk_valid = 1'b0;
      for (int k = 0; k < NIB; k++) begin
         check_nibble("b2b blk2", d2, k);
         @(negedge clock);
      end
      chk("b2b end nib_valid", 128'(nib_valid), 128'(1'b0));
      nib_ready = 1'b0;

      // reset mid-block at index 20
      wait_ready("rstmid");
      blk_data  = D_REF;
      blk_valid = 1'b1;
      nib_ready = 1'b1;
      @(negedge clock);
      blk_valid = 1'b0;
      for (int k = 0; k < NIB; k++) begin
         if (exp_idx(k) == 20) break;
         @(negedge clock);
      end
      chk("rstmid pre index", 128'(mux_index), 128'(20));
      #2 reset = 1'b1;
      #1;
      chk("rstmid nib_valid", 128'(nib_valid), 128'(1'b0));
      chk("rstmid nib_last", 128'(nib_last), 128'(1'b0));
      chk("rstmid blk_ready", 128'(blk_ready), 128'(1'b1));
      chk("rstmid mux_index", 128'(mux_index), 128'(0));
      chk("rstmid mux_in", mux_in, 128'(0));
      @(negedge clock);
      reset = 1'b0;
      for (int c = 0; c < 5; c++) begin
         @(negedge clock);
         chk("rstmid after nib_valid", 128'(nib_valid), 128'(1'b0));
         chk("rstmid after mux_index", 128'(mux_index), 128'(0));
      end
      nib_ready = 1'b0;
      run_block(vecs[0], "recover");

      // randomized blocks against the reference model
      for (int r = 0; r < 15; r++) begin
         rv.data       = {$urandom, $urandom, $urandom, $urandom};
         rv.stall_at   = $urandom_range(0, NIB - 1);
         rv.stall_len  = $urandom_range(0, 4);
         rv.flush_at   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, NIB - 1)) : -1;
         rv.rand_ready = 1'b1;
         rv.exp_cycles = -1;
         run_block(rv, $sformatf("rand%0d", r));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
